// File: rtl/prio_code_pkg.sv
// Shared definitions for the priority-code decoder: default code width,
// occupancy state encoding and the code-width to word-width helper.
package prio_code_pkg;

   localparam int DEF_W = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   function automatic int n_from_w(input int w);
      return 1 << w;
   endfunction

endpackage

// File: rtl/code2onehot.sv
// Combinational W->N decoder; a set none flag forces an all-zero word.
module code2onehot
   import prio_code_pkg::*;
#(
   parameter int W = DEF_W,
   parameter int N = n_from_w(DEF_W)
) (
   input  logic [W-1:0] code,
   input  logic         none,
   output logic [N-1:0] word
);

   always_comb begin
      word = '0;
      if (!none) begin
         word[code] = 1'b1;
      end
   end

endmodule

// File: rtl/prio_code_decoder.sv
// Decodes an index/none pair into a one-hot word behind a two-entry skid
// buffer with ready/valid on both sides, plus a saturating none counter.
module prio_code_decoder
   import prio_code_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int CNT_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [W-1:0]              in_code,
   input  logic                      in_none,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [n_from_w(W)-1:0]    out_onehot,
   output logic [CNT_W-1:0]          none_cnt
);

   localparam int N = n_from_w(W);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   occ_t           state;
   logic [N-1:0]   word_p0;
   logic [N-1:0]   head_p1;
   logic [N-1:0]   skid_p1;
   logic           in_xfer;
   logic           out_xfer;

   code2onehot #(
      .W (W),
      .N (N)
   ) u_dec (
      .code (in_code),
      .none (in_none),
      .word (word_p0)
   );

   // in_ready depends only on registered occupancy (and rst), never on out_ready.
   assign in_ready   = !rst && (state != TWO);
   assign out_valid  = (state != EMPTY);
   assign out_onehot = out_valid ? head_p1 : '0;
   assign in_xfer    = in_valid && in_ready;
   assign out_xfer   = out_valid && out_ready;

   // ---- p0 -> p1: decoded word enters head or skid entry ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         head_p1  <= '0;
         skid_p1  <= '0;
         none_cnt <= '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_xfer) begin
                  head_p1 <= word_p0;
                  state   <= ONE;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  head_p1 <= word_p0;
               end else if (in_xfer) begin
                  skid_p1 <= word_p0;
                  state   <= TWO;
               end else if (out_xfer) begin
                  state   <= EMPTY;
               end
            end
            TWO: begin
               if (out_xfer) begin
                  head_p1 <= skid_p1;
                  state   <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase

         if (in_xfer && in_none) begin
            none_cnt <= sat_inc(none_cnt);
         end
      end
   end

endmodule

// File: tb/tb_prio_code_decoder.sv
// Self-checking bench for prio_code_decoder: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_prio_code_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] in_code = 2'd0;
   logic       in_none = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_onehot;
   logic [7:0] none_cnt;

   int tests = 0;
   int fails = 0;

   logic [3:0] q[$];
   int         cnt = 0;

   always #5 clk = ~clk;

   prio_code_decoder #(
      .W     (2),
      .CNT_W (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_code    (in_code),
      .in_none    (in_none),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .none_cnt   (none_cnt)
   );

   function automatic logic exp_valid();
      return q.size() > 0;
   endfunction

   function automatic logic [3:0] exp_word();
      return (q.size() > 0) ? q[0] : 4'd0;
   endfunction

   function automatic logic exp_ready();
      return !rst && (q.size() < 2);
   endfunction

   // Advance one clock, updating the reference model from the inputs present at the edge.
   task automatic cycle();
      bit ix, ox;
      logic [3:0] w;
      ix = in_valid && !rst && (q.size() < 2);
      ox = !rst && (q.size() > 0) && out_ready;
      w  = in_none ? 4'd0 : 4'(1 << in_code);
      @(posedge clk);
      if (rst) begin
         q.delete();
         cnt = 0;
      end else begin
         if (ox) void'(q.pop_front());
         if (ix) begin
            q.push_back(w);
            if (in_none && cnt < 255) cnt++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      cycle(); cycle();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      tests++; if (out_onehot !== 4'd0) begin fails++; $display("FAIL reset_word: got %b expected 0000", out_onehot); end
      tests++; if (none_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", none_cnt); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_in_rst: got %b expected 0", in_ready); end
      rst = 1'b0; #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %b expected 1", in_ready); end
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_code = 2'd2; in_none = 1'b0; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", out_valid); end
      tests++; if (out_onehot !== 4'b0100) begin fails++; $display("FAIL single_word: got %b expected 0100", out_onehot); end
      cycle();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain_valid: got %b expected 0", out_valid); end
      tests++; if (out_onehot !== 4'd0) begin fails++; $display("FAIL single_drain_word: got %b expected 0000", out_onehot); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] codes [3];
      logic [3:0] words [3];
      codes = '{2'd3, 2'd0, 2'd1};
      words = '{4'b1000, 4'b0001, 4'b0010};
      out_ready = 1'b1; in_none = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_code = codes[i];
         cycle();
         tests++; if (out_onehot !== words[i]) begin fails++; $display("FAIL b2b_word%0d: got %b expected %b", i, out_onehot, words[i]); end
         tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d: got %b expected 1", i, in_ready); end
      end
      in_valid = 1'b0;
      cycle();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_stall();
      out_ready = 1'b0; in_none = 1'b0; in_valid = 1'b1;
      in_code = 2'd1; cycle();
      in_code = 2'd2; cycle();
      in_valid = 1'b0;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_full_ready: got %b expected 0", in_ready); end
      tests++; if (out_onehot !== 4'b0010) begin fails++; $display("FAIL stall_word: got %b expected 0010", out_onehot); end
      cycle(); cycle();
      tests++; if (out_onehot !== 4'b0010) begin fails++; $display("FAIL stall_hold: got %b expected 0010", out_onehot); end
      out_ready = 1'b1; #1;
      tests++; if (out_onehot !== 4'b0010) begin fails++; $display("FAIL stall_pop1: got %b expected 0010", out_onehot); end
      cycle();
      tests++; if (out_onehot !== 4'b0100) begin fails++; $display("FAIL stall_pop2: got %b expected 0100", out_onehot); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_ready_back: got %b expected 1", in_ready); end
      cycle();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_empty: got %b expected 0", out_valid); end
   endtask

   task automatic test_none();
      in_valid = 1'b1; in_none = 1'b1; in_code = 2'd3; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL none_valid: got %b expected 1", out_valid); end
      tests++; if (out_onehot !== 4'd0) begin fails++; $display("FAIL none_word: got %b expected 0000", out_onehot); end
      tests++; if (none_cnt !== 8'd1) begin fails++; $display("FAIL none_cnt1: got %0d expected 1", none_cnt); end
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_code = 2'($urandom_range(0, 3));
         cycle();
         tests++; if (none_cnt !== 8'(cnt)) begin fails++; $display("FAIL none_cnt_step%0d: got %0d expected %0d", i, none_cnt, cnt); end
      end
      in_valid = 1'b0; in_none = 1'b0;
      cycle();
      tests++; if (none_cnt !== 8'd255) begin fails++; $display("FAIL none_sat: got %0d expected 255", none_cnt); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_none = 1'b0; in_valid = 1'b1;
      in_code = 2'd1; cycle();
      in_code = 2'd2; cycle();
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rmid_full: got %b expected 0", in_ready); end
      rst = 1'b1; in_code = 2'd3; out_ready = 1'b1; #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready_rst: got %b expected 0", in_ready); end
      cycle();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
      tests++; if (none_cnt !== 8'd0) begin fails++; $display("FAIL rmid_cnt: got %0d expected 0", none_cnt); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready_hi: got %b expected 0", in_ready); end
      rst = 1'b0; in_valid = 1'b0; #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready_after: got %b expected 1", in_ready); end
      cycle();
      tests++; if (out_valid !== 1'b0 || out_onehot !== 4'd0) begin fails++; $display("FAIL rmid_stale: got valid=%b word=%b expected 0/0000", out_valid, out_onehot); end
   endtask

   task automatic test_random();
      logic       prev_stall;
      logic [3:0] prev_word;
      prev_stall = 1'b0; prev_word = 4'd0;
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_code   = 2'($urandom_range(0, 3));
         in_none   = ($urandom_range(0, 7) == 0);
         prev_stall = out_valid && !out_ready;
         prev_word  = out_onehot;
         cycle();
         tests++;
         if (out_valid !== exp_valid() || out_onehot !== exp_word() ||
             in_ready !== exp_ready() || none_cnt !== 8'(cnt)) begin
            fails++;
            $display("FAIL rand_cycle%0d: got v=%b w=%b r=%b c=%0d expected v=%b w=%b r=%b c=%0d",
                     i, out_valid, out_onehot, in_ready, none_cnt,
                     exp_valid(), exp_word(), exp_ready(), cnt);
         end
         if (prev_stall) begin
            tests++;
            if (out_onehot !== prev_word) begin
               fails++;
               $display("FAIL rand_stable%0d: got %b expected %b", i, out_onehot, prev_word);
            end
         end
         tests++;
         if ($countones(out_onehot) > 1) begin
            fails++;
            $display("FAIL rand_onehot%0d: got %b expected at most one bit", i, out_onehot);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_none();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
